div_seq_unit: RTL and testbench
===============================

Name: div_seq_unit

Overview:
- Multicycle signed 32-bit integer divider for the CPU's DIV instruction.
- Fed by the ALU A/B operand muxes; the quotient and remainder go to the HI/LO select muxes.
- It raises a divide-by-zero flag that the control unit routes to the exception path.
- Uses a start/busy/done handshake so the control FSM can wait on completion instead of a fixed cycle count.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (rs), sampled on the accepting edge.
- divisor  input  WIDTH  signed divisor (rt), sampled on the accepting edge.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle divide-by-zero pulse.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). The polarity and synchronicity are fixed.
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, internal regs=0. Reset wins over all other inputs and aborts any division in progress. No result is written on abort.
- IDLE state:
  - start=1 and divisor==0: stay IDLE, done=1 and div_zero=1 for one cycle, hi/lo unchanged.
  - start=1 and divisor!=0: latch |dividend| and |divisor| as unsigned magnitudes, plus the sign bits (quotient sign = XOR of the operand signs, remainder sign = dividend sign). Clear the partial remainder, set count=WIDTH, busy=1, go to RUN.
- RUN state: restoring division, one quotient bit per clock.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep it and set the quotient LSB to 1.
  - Decrement count; after WIDTH iterations go to FIX.
- FIX state:
  - lo = quotient, negated if the quotient sign is set.
  - hi = remainder, negated if the remainder sign is set.
  - done=1 for the next cycle, busy=0, go to IDLE.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+WIDTH; FIX at edge k+WIDTH+1. hi/lo and done become valid after edge k+WIDTH+1 (33 cycles for WIDTH=32).
- Semantics follow MIPS: quotient truncates toward zero, remainder takes the sign of the dividend.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag. This falls out of the magnitude arithmetic because |INT_MIN| = 0x80000000 unsigned.
- start while busy=1 is ignored; operands are not re-sampled.
- start asserted in the same cycle that done=1 is accepted, since the FSM is already in IDLE.
- hi/lo hold their value until the next successful completion or reset.
- dividend/divisor may change after the accepting edge without effect.
- The divide-by-zero case never asserts busy.

Test Plan:
1. reset=1 for 2 cycles, then release -> hi=0, lo=0, busy=0, done=0, div_zero=0.
2. start with dividend=100, divisor=7 -> busy for 33 cycles, then a single done pulse with lo=14, hi=2.
3. dividend=0xFFFFFFF9 (-7), divisor=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 7/-2 -> lo=0xFFFFFFFD, hi=1.
4. dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
5. Prior result lo=14/hi=2, then start 5/0 -> done=1 and div_zero=1 on the next cycle, busy stays 0, hi=2 and lo=14 unchanged.
6. Robustness, in one run:
   - Start 100/7, then pulse start with 9/3 at cycle 10 -> second start ignored, result still 14/2.
   - Assert reset at cycle 20 of a new division -> busy=0 next cycle, no done, hi=lo=0.
   - Back-to-back start in the done cycle -> the second result arrives 33 cycles later.

Source files
------------

// File: rtl/div_seq_unit.sv
// Multicycle signed restoring divider for the DIV instruction.
// The unit divides operand magnitudes, producing one quotient bit per clock,
// then applies the signs in a final fix-up cycle. The quotient truncates
// toward zero and the remainder takes the sign of the dividend.
// Divide-by-zero completes in one cycle with a flag and leaves hi/lo untouched.
module div_seq_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             qsign_q, qsign_d;
   logic             rsign_q, rsign_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH:0]   shift_s;
   logic [WIDTH:0]   trial_s;

   // Two's-complement negation.
   function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Unsigned magnitude of a signed value; INT_MIN maps to 2^(WIDTH-1), which
   // is exactly what the unsigned datapath needs.
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? neg_f(v) : v;
   endfunction

   // Shift the next dividend bit into the remainder and trial-subtract the divisor.
   always_comb begin
      shift_s = {rem_q, quo_q[WIDTH-1]};
      trial_s = shift_s - {1'b0, dvs_q};
   end

   // Next-state and datapath update for the IDLE/RUN/FIX sequence.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (divisor == {WIDTH{1'b0}}) begin
                  done_d = 1'b1;
                  dz_d   = 1'b1;
               end else begin
                  quo_d   = mag_f(dividend);
                  dvs_d   = mag_f(divisor);
                  rem_d   = {WIDTH{1'b0}};
                  qsign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  rsign_d = dividend[WIDTH-1];
                  cnt_d   = CW'(WIDTH);
                  busy_d  = 1'b1;
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (trial_s[WIDTH] == 1'b0) begin
               rem_d = trial_s[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shift_s[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FIX: begin
            lo_d    = qsign_q ? neg_f(quo_q) : quo_q;
            hi_d    = rsign_q ? neg_f(rem_q) : rem_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset; reset aborts any division.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rem_q   <= {WIDTH{1'b0}};
         quo_q   <= {WIDTH{1'b0}};
         dvs_q   <= {WIDTH{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Scoreboard bench for div_seq_unit: the driver pushes the expected result
// and completion cycle when it issues a division; a monitor pops and compares
// on every done pulse.
module tb_div_seq_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  dividend = 32'h0;
   logic [W-1:0]  divisor = 32'h0;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          busy;
   logic          done;
   logic          div_zero;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   div_seq_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .dividend(dividend), .divisor(divisor),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   // Clock
   always #5 clk = ~clk;

   // Cycle counter, stepped on each active edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("lo", {32'h0, lo}, {32'h0, mon_e.lo});
            chk("hi", {32'h0, hi}, {32'h0, mon_e.hi});
            chk("div_zero", {63'h0, div_zero}, {63'h0, mon_e.dz});
            chk("busy_at_done", {63'h0, busy}, 64'h0);
            chk("done_cycle", 64'(cyc), 64'(mon_e.at));
         end
      end
   end

   // Called just after a negedge: request a division and record the expected outcome.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
      exp_t e;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      e.hi = ehi;
      e.lo = elo;
      e.dz = edz;
      e.at = cyc + 1 + (edz ? 0 : W + 1);
      sb.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      dividend = 32'hDEAD_BEEF;
      divisor  = 32'h0000_0003;
      chk("busy_after_start", {63'h0, busy}, edz ? 64'h0 : 64'h1);
   endtask

   // Wait (bounded) until every expected result has been seen.
   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   // Directed stimulus
   initial begin
      int n;
      // reset held for two edges, then released
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_hi", {32'h0, hi}, 64'h0);
      chk("rst_lo", {32'h0, lo}, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_dz", {63'h0, div_zero}, 64'h0);

      // basic and signed cases
      issue(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);              wait_drain(40);
      issue(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0); wait_drain(40);
      issue(32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);  wait_drain(40);
      issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b0); wait_drain(40);
      issue(32'd5, 32'd100, 32'd5, 32'd0, 1'b0);                wait_drain(40);
      // overflow and extreme magnitudes
      issue(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0); wait_drain(40);
      issue(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0); wait_drain(40);

      // divide by zero keeps the previous result
      issue(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);              wait_drain(40);
      issue(32'd5, 32'd0, 32'd2, 32'd14, 1'b1);                 wait_drain(5);
      chk("dz_pulse_cleared", {63'h0, div_zero}, 64'h0);
      chk("dz_busy", {63'h0, busy}, 64'h0);

      // make hi/lo differ before the robustness run
      issue(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0); wait_drain(40);

      // start while busy is ignored
      issue(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      repeat (9) @(negedge clk);
      dividend = 32'd9;
      divisor  = 32'd3;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_drain(40);

      // reset in the middle of a division aborts it with no result
      dividend = 32'd9;
      divisor  = 32'd3;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", {63'h0, busy}, 64'h0);
      chk("abort_done", {63'h0, done}, 64'h0);
      chk("abort_hi", {32'h0, hi}, 64'h0);
      chk("abort_lo", {32'h0, lo}, 64'h0);
      reset = 1'b0;
      repeat (40) @(negedge clk);

      // back-to-back start in the done cycle
      issue(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL b2b_wait: got done=%b expected 1 within 40 cycles", done);
      end
      issue(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
      wait_drain(40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
